// File: rtl/copper_sequencer.sv
// copper_sequencer: copper instruction sequencer.
// Fetches 16-bit copper words from the copper program BRAM (1-cycle read latency),
// decodes MOVE / WAIT / JUMP / SKIP / NOP against the beam position and issues
// XR register writes to the register arbiter. Restarts at address 0 on every EOF.
//
// Latency : one-word instructions take 2 cycles (ADDR, EXEC); MOVE takes
//           ADDR, EXEC, MADDR, MDATA, WRITE (5 cycles minimum) plus any ack wait.
// Backpressure: a write is held in WRITE until xr_wr_ack_i; en_i low or eof_i
//           abandon the pending write.
//
// Build option:
//   COPPER_SKIP_EN  defined   -> opcode 011 is SKIP (conditional PC += 3)
//                   undefined -> opcode 011 decodes as NOP, no SKIP compare logic
//
// Ports:
//   clk, reset_i        sole clock, synchronous active-high reset
//   en_i                copper enable, low forces HALT
//   eof_i               one-cycle end-of-frame pulse
//   h_count_i/v_count_i current beam position
//   rd_address_o        BRAM read address (the registered PC)
//   rd_data_i           BRAM read data, valid one cycle after the address
//   xr_wr_en_o          XR write request, held until xr_wr_ack_i
//   xr_addr_o/xr_data_o XR write address and data, stable while requesting

module copper_sequencer #(
   parameter int AWIDTH = 10
) (
   input  logic              clk,
   input  logic              reset_i,
   input  logic              en_i,
   input  logic              eof_i,
   input  logic [10:0]       h_count_i,
   input  logic [10:0]       v_count_i,
   output logic [AWIDTH-1:0] rd_address_o,
   input  logic [15:0]       rd_data_i,
   output logic              xr_wr_en_o,
   input  logic              xr_wr_ack_i,
   output logic [11:0]       xr_addr_o,
   output logic [15:0]       xr_data_o
);

   localparam logic [2:0] OP_MOVE = 3'b000;
   localparam logic [2:0] OP_WAIT = 3'b001;
   localparam logic [2:0] OP_JUMP = 3'b010;
`ifdef COPPER_SKIP_EN
   localparam logic [2:0] OP_SKIP = 3'b011;
`endif

   typedef enum logic [2:0] {
      HALT,
      ADDR,
      EXEC,
      MADDR,
      MDATA,
      WRITE,
      WAITING
   } state_t;

   state_t            state;
   logic [AWIDTH-1:0] pc;

   // Only the compare fields of a WAIT word are kept; the opcode is implied
   // by being in WAITING. [12] selects h/v, [11] means "EOF only", [10:0] position.
   logic [12:0]       wait_word;

   logic              wait_pos_met;
   logic              wait_done;
   logic [AWIDTH-1:0] pc_inc;

   // The PC is a register, so the BRAM address is registered by construction.
   assign rd_address_o = pc;

   // Natural AWIDTH-bit overflow gives the modulo-2^AWIDTH wrap.
   assign pc_inc = pc + AWIDTH'(1);

   // WAIT compare runs on the latched word so a changing rd_data_i during the
   // wait has no effect. With [11] set only eof_i (handled by priority) exits.
   always_comb begin
      wait_pos_met = 1'b0;
      if (wait_word[12]) begin
         wait_pos_met = (h_count_i >= wait_word[10:0]);
      end else begin
         wait_pos_met = (v_count_i >= wait_word[10:0]);
      end
      wait_done = wait_pos_met && !wait_word[11];
   end

`ifdef COPPER_SKIP_EN
   // SKIP is decided in EXEC directly from the fresh BRAM word; [11] is ignored.
   logic skip_met;
   always_comb begin
      skip_met = 1'b0;
      if (rd_data_i[12]) begin
         skip_met = (h_count_i >= rd_data_i[10:0]);
      end else begin
         skip_met = (v_count_i >= rd_data_i[10:0]);
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset_i) begin
         state      <= HALT;
         pc         <= '0;
         wait_word  <= '0;
         xr_wr_en_o <= 1'b0;
         xr_addr_o  <= '0;
         xr_data_o  <= '0;
      end else if (!en_i) begin
         // Disable wins over everything but reset; a pending write is dropped.
         state      <= HALT;
         pc         <= '0;
         xr_wr_en_o <= 1'b0;
      end else if (eof_i) begin
         // Frame restart from any state, also beating a WAIT that is
         // satisfied in the same cycle.
         state      <= ADDR;
         pc         <= '0;
         xr_wr_en_o <= 1'b0;
      end else begin
         case (state)
            HALT: begin
               pc    <= '0;
               state <= ADDR;
            end

            ADDR: begin
               state <= EXEC;
            end

            EXEC: begin
               case (rd_data_i[15:13])
                  OP_MOVE: begin
                     xr_addr_o <= rd_data_i[11:0];
                     pc        <= pc_inc;
                     state     <= MADDR;
                  end
                  OP_WAIT: begin
                     wait_word <= rd_data_i[12:0];
                     state     <= WAITING;
                  end
                  OP_JUMP: begin
                     pc    <= rd_data_i[AWIDTH-1:0];
                     state <= ADDR;
                  end
`ifdef COPPER_SKIP_EN
                  OP_SKIP: begin
                     pc    <= skip_met ? (pc + AWIDTH'(3)) : pc_inc;
                     state <= ADDR;
                  end
`endif
                  default: begin
                     // NOP (and opcode 011 when SKIP is not built)
                     pc    <= pc_inc;
                     state <= ADDR;
                  end
               endcase
            end

            MADDR: begin
               state <= MDATA;
            end

            MDATA: begin
               xr_data_o  <= rd_data_i;
               xr_wr_en_o <= 1'b1;
               pc         <= pc_inc;
               state      <= WRITE;
            end

            WRITE: begin
               // Request, address and data hold until the ack cycle; the
               // request drops on the very next edge.
               if (xr_wr_ack_i) begin
                  xr_wr_en_o <= 1'b0;
                  state      <= ADDR;
               end
            end

            WAITING: begin
               if (wait_done) begin
                  pc    <= pc_inc;
                  state <= ADDR;
               end
            end

            default: begin
               state      <= HALT;
               pc         <= '0;
               xr_wr_en_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_copper_sequencer.sv
// tb_copper_sequencer: directed bench for copper_sequencer.
// Models the copper BRAM (1-cycle read latency) and walks WAIT-EOF, MOVE,
// WAIT vertical, JUMP/wrap, SKIP and abort scenarios with hand-computed results.

module tb_copper_sequencer;

   localparam int AWIDTH = 10;

   logic              clk = 1'b0;
   logic              reset;
   logic              en;
   logic              eof;
   logic [10:0]       h_count;
   logic [10:0]       v_count;
   logic [AWIDTH-1:0] rd_address;
   logic [15:0]       rd_data;
   logic              xr_wr_en;
   logic              xr_wr_ack;
   logic [11:0]       xr_addr;
   logic [15:0]       xr_data;

   logic [15:0] mem [0:(1<<AWIDTH)-1];

   int checks = 0;
   int errors = 0;
   int seen_wr;
   int moved;

   copper_sequencer #(.AWIDTH(AWIDTH)) dut (
      .clk          (clk),
      .reset_i      (reset),
      .en_i         (en),
      .eof_i        (eof),
      .h_count_i    (h_count),
      .v_count_i    (v_count),
      .rd_address_o (rd_address),
      .rd_data_i    (rd_data),
      .xr_wr_en_o   (xr_wr_en),
      .xr_wr_ack_i  (xr_wr_ack),
      .xr_addr_o    (xr_addr),
      .xr_data_o    (xr_data)
   );

   always #5 clk = ~clk;

   // Copper program BRAM: synchronous read, data one cycle after address.
   always @(posedge clk) rd_data <= mem[rd_address];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Unprogrammed words park the sequencer on "wait EOF".
   task automatic clear_mem();
      for (int i = 0; i < (1 << AWIDTH); i++) mem[i] = 16'h2BFF;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      en        = 1'b0;
      eof       = 1'b0;
      xr_wr_ack = 1'b0;
      h_count   = '0;
      v_count   = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Watchdog: the sequence is linear, this only guards against a stuck sim.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---------------- reset + WAIT EOF loop ----------------
      clear_mem();
      mem[0] = 16'h2BFF;
      do_reset();
      chk("reset_rd_address", 32'(rd_address), 32'h0);
      chk("reset_wr_en", 32'(xr_wr_en), 32'h0);
      chk("reset_xr_addr", 32'(xr_addr), 32'h0);
      chk("reset_xr_data", 32'(xr_data), 32'h0);

      en = 1'b1;
      tick();                                   // ADDR
      chk("start_addr", 32'(rd_address), 32'h0);
      tick();                                   // EXEC
      tick();                                   // WAITING
      seen_wr = 0;
      moved   = 0;
      for (int i = 0; i < 20; i++) begin
         v_count = 11'(i * 50);
         h_count = 11'(i * 97);
         tick();
         if (xr_wr_en !== 1'b0) seen_wr++;
         if (rd_address !== '0) moved++;
      end
      chk("waiteof_no_write", 32'(seen_wr), 32'd0);
      chk("waiteof_addr_held", 32'(moved), 32'd0);
      // Replace word 0 by JUMP 5: only a genuine re-fetch after EOF reaches 5.
      mem[0] = 16'h4005;
      eof = 1'b1;
      tick();                                   // ADDR, pc 0
      eof = 1'b0;
      chk("eof_refetch_addr", 32'(rd_address), 32'h0);
      tick();                                   // EXEC JUMP
      tick();                                   // ADDR 5
      chk("eof_refetch_jump", 32'(rd_address), 32'h5);

      // ---------------- MOVE, ack tied high ----------------
      clear_mem();
      mem[0] = 16'h0012;
      mem[1] = 16'hABCD;
      do_reset();
      xr_wr_ack = 1'b1;
      en = 1'b1;
      tick();                                   // ADDR
      tick();                                   // EXEC
      tick();                                   // MADDR
      chk("move_maddr_rd", 32'(rd_address), 32'h1);
      chk("move_maddr_xaddr", 32'(xr_addr), 32'h012);
      chk("move_maddr_wren", 32'(xr_wr_en), 32'h0);
      tick();                                   // MDATA
      chk("move_mdata_wren", 32'(xr_wr_en), 32'h0);
      tick();                                   // WRITE
      chk("move_write_wren", 32'(xr_wr_en), 32'h1);
      chk("move_write_addr", 32'(xr_addr), 32'h012);
      chk("move_write_data", 32'(xr_data), 32'hABCD);
      tick();                                   // ADDR 2
      chk("move_after_wren", 32'(xr_wr_en), 32'h0);
      chk("move_next_fetch", 32'(rd_address), 32'h2);
      seen_wr = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (xr_wr_en !== 1'b0) seen_wr++;
      end
      chk("move_single_pulse", 32'(seen_wr), 32'd0);

      // ---------------- MOVE, ack delayed 3 cycles ----------------
      do_reset();
      en = 1'b1;
      for (int i = 0; i < 5; i++) tick();       // through WRITE entry
      chk("mvdly_wren", 32'(xr_wr_en), 32'h1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("mvdly_hold_wren", 32'(xr_wr_en), 32'h1);
         chk("mvdly_hold_addr", 32'(xr_addr), 32'h012);
         chk("mvdly_hold_data", 32'(xr_data), 32'hABCD);
      end
      xr_wr_ack = 1'b1;
      tick();
      xr_wr_ack = 1'b0;
      chk("mvdly_release_wren", 32'(xr_wr_en), 32'h0);
      chk("mvdly_next_fetch", 32'(rd_address), 32'h2);

      // ---------------- WAIT vertical ----------------
      clear_mem();
      mem[0] = 16'h2064;
      do_reset();
      en = 1'b1;
      tick();
      tick();
      tick();                                   // WAITING
      moved = 0;
      for (int i = 95; i < 100; i++) begin
         v_count = 11'(i);
         h_count = 11'h7FF - 11'(i);
         tick();
         if (rd_address !== '0) moved++;
      end
      chk("waitv_below_held", 32'(moved), 32'd0);
      v_count = 11'd100;
      tick();
      chk("waitv_release", 32'(rd_address), 32'h1);

      // EOF beats a WAIT compare satisfied in the same cycle.
      do_reset();
      en = 1'b1;
      tick();
      tick();
      tick();                                   // WAITING
      v_count = 11'd100;
      eof = 1'b1;
      tick();
      eof = 1'b0;
      chk("waitv_eof_priority", 32'(rd_address), 32'h0);
      tick();                                   // EXEC
      tick();                                   // WAITING
      chk("waitv_eof_reenter", 32'(rd_address), 32'h0);
      tick();
      chk("waitv_eof_then_release", 32'(rd_address), 32'h1);

      // ---------------- JUMP / wrap ----------------
      clear_mem();
      mem[0] = 16'h4005;
      do_reset();
      en = 1'b1;
      tick();
      tick();
      tick();
      chk("jump_target", 32'(rd_address), 32'h5);

      clear_mem();
      mem[0]    = 16'h43FF;
      mem[1023] = 16'h8000;
      do_reset();
      en = 1'b1;
      tick();
      tick();
      tick();
      chk("jump_to_top", 32'(rd_address), 32'h3FF);
      tick();                                   // EXEC NOP
      tick();
      chk("nop_wrap", 32'(rd_address), 32'h0);

      // ---------------- SKIP ----------------
      clear_mem();
      mem[0] = 16'h6032;
      do_reset();
      v_count = 11'd60;
      en = 1'b1;
      tick();
      tick();
      tick();
`ifdef COPPER_SKIP_EN
      chk("skip_true", 32'(rd_address), 32'h3);
`else
      chk("skip_true_as_nop", 32'(rd_address), 32'h1);
`endif
      do_reset();
      v_count = 11'd40;
      en = 1'b1;
      tick();
      tick();
      tick();
      chk("skip_false", 32'(rd_address), 32'h1);

      // ---------------- Abort: EOF during WRITE ----------------
      clear_mem();
      mem[0] = 16'h0012;
      mem[1] = 16'h1234;
      do_reset();
      en = 1'b1;
      for (int i = 0; i < 5; i++) tick();       // WRITE, ack low
      chk("abort_eof_pre_wren", 32'(xr_wr_en), 32'h1);
      tick();
      eof = 1'b1;
      tick();
      eof = 1'b0;
      chk("abort_eof_wren", 32'(xr_wr_en), 32'h0);
      chk("abort_eof_rd", 32'(rd_address), 32'h0);

      // ---------------- Abort: en_i dropped mid-MOVE ----------------
      do_reset();
      xr_wr_ack = 1'b1;
      en = 1'b1;
      for (int i = 0; i < 4; i++) tick();       // MDATA
      en = 1'b0;
      tick();
      chk("abort_en_wren", 32'(xr_wr_en), 32'h0);
      chk("abort_en_rd", 32'(rd_address), 32'h0);
      seen_wr = 0;
      moved   = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (xr_wr_en !== 1'b0) seen_wr++;
         if (rd_address !== '0) moved++;
      end
      chk("abort_en_no_write", 32'(seen_wr), 32'd0);
      chk("abort_en_halted", 32'(moved), 32'd0);
      chk("abort_en_data_untouched", 32'(xr_data), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
